// File: rtl/alu_pkg.sv
// Shared ALU types and defaults for the folded
// ripple-borrow subtractor.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice counter; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ripple_borrow_subtractor_seq_if.sv
// Operand/result valid-ready bundle for the
// sequential subtractor.
interface ripple_borrow_subtractor_seq_if #(
  parameter int WIDTH = alu_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff,
    input  bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff,
    output bout, zero, ovf
  );

endinterface

// File: rtl/ripple_borrow_subtractor_seq_full_subtractor.sv
// One-bit full subtractor cell:
// d = a - b - bin, bout set when it underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// WIDTH-bit subtractor folded in time: one CHUNK
// slice per clock, LSB first, borrow registered.
module ripple_borrow_subtractor_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic                          clk,
  input logic                          rst_n,
  ripple_borrow_subtractor_seq_if.slave bus
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IW = idx_w(NUM_CHUNKS);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [IW-1:0]    idx;
  logic             brw;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;

  logic             in_ready;
  logic             out_valid;
  logic             last;
  logic [31:0]      off;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] d_sl;
  logic [CHUNK:0]   c;
  logic [WIDTH-1:0] diff_n;

  assign last = (idx == IW'(NUM_CHUNKS - 1));
  assign off  = 32'(idx) * 32'(CHUNK);
  assign a_sl = a_s[off +: CHUNK];
  assign b_sl = b_s[off +: CHUNK];
  assign c[0] = brw;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    full_subtractor u_fs (
      .a    (a_sl[i]),
      .b    (b_sl[i]),
      .bin  (c[i]),
      .d    (d_sl[i]),
      .bout (c[i+1])
    );
  end

  always_comb begin
    diff_n = diff_q;
    diff_n[off +: CHUNK] = d_sl;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = 1'b1;
        if (bus.in_valid) state_n = RUN;
      end
      (state == RUN): begin
        if (last) state_n = DONE;
      end
      (state == DONE): begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s    <= '0;
      b_s    <= '0;
      idx    <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        a_s <= bus.a;
        b_s <= bus.b;
        brw <= bus.bin;
        idx <= '0;
      end
    end else if (state == RUN) begin
      diff_q <= diff_n;
      brw    <= c[CHUNK];
      idx    <= idx + IW'(1);
      // Flags settle on the final slice edge only.
      if (last) begin
        bout_q <= c[CHUNK];
        zero_q <= ~|diff_n;
        ovf_q  <= (a_s[WIDTH-1] != b_s[WIDTH-1])
               && (diff_n[WIDTH-1] != a_s[WIDTH-1]);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// Scoreboard bench for the sequential subtractor:
// random + directed operands vs an arithmetic model.
module tb_ripple_borrow_subtractor_seq;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int NC = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
    logic         ov;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   prev_ov = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ripple_borrow_subtractor_seq_if #(.WIDTH(W)) bus();

  ripple_borrow_subtractor_seq #(
    .WIDTH (W),
    .CHUNK (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic exp_t model(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic bi, input int acc);
    exp_t e;
    logic [W:0] w;
    longint s;
    w = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
    s = longint'($signed(a)) - longint'($signed(b))
      - longint'(bi);
    e.d   = w[W-1:0];
    e.bo  = w[W];
    e.z   = (w[W-1:0] == '0);
    e.ov  = (s > 64'sd2147483647)
         || (s < -64'sd2147483648);
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic bi, input bit push,
                      output int acc);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    acc  = -1;
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bi;
    bus.in_valid = 1'b1;
    while (!done && n < 200) begin
      if (bus.in_ready) begin
        acc = cyc + 1;
        if (push) q.push_back(model(a, b, bi, acc));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        done         = 1'b1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got none want accept");
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d left want 0",
               q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got valid want idle");
      end else begin
        chk("diff", 64'(bus.diff), 64'(q[0].d));
        chk("bout", 64'(bus.bout), 64'(q[0].bo));
        chk("zero", 64'(bus.zero), 64'(q[0].z));
        chk("ovf", 64'(bus.ovf), 64'(q[0].ov));
        chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
        if (!prev_ov)
          chk("latency", 64'(cyc - q[0].acc), 64'(NC));
        if (bus.out_ready) void'(q.pop_front());
      end
    end
    prev_ov = rst_n && bus.out_valid;
  end

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  int acc;
  int acc2;
  int rel;
  int n;

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_diff", 64'(bus.diff), 64'd0);
    chk("rst_flags",
        64'({bus.bout, bus.zero, bus.ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h5, 32'h3, 1'b0, 1'b1, acc);
    drain();
    send(32'h0, 32'h1, 1'b0, 1'b1, acc);
    drain();
    send(32'h80000000, 32'h1, 1'b0, 1'b1, acc);
    drain();
    send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, acc);
    drain();
    send(32'h12345678, 32'h12345677, 1'b1, 1'b1, acc);
    drain();
    send(32'h0, 32'hFFFFFFFF, 1'b1, 1'b1, acc);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : 32'($urandom);
      if (i % 7 == 0) ra = 32'hFFFFFFFF;
      send(ra, rb, 1'($urandom), 1'b1, acc);
      bus.out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.out_ready = 1'b1;
    end
    drain();

    bus.out_ready = 1'b0;
    send(32'd100, 32'd37, 1'b0, 1'b1, acc);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
    acc2 = -1;
    fork
      send(32'd9, 32'd4, 1'b0, 1'b1, acc2);
    join_none
    repeat (10) @(negedge clk);
    rel = cyc;
    bus.out_ready = 1'b1;
    wait fork;
    chk("bp_accept_late", 64'(acc2 >= rel + 2), 64'd1);
    drain();

    send(32'h55, 32'h22, 1'b0, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_diff", 64'(bus.diff), 64'd0);
    chk("mid_rst_flags",
        64'({bus.bout, bus.zero, bus.ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h100, 32'h1, 1'b0, 1'b1, acc);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
